// File: rtl/morse_char_sequencer.sv
// Byte FIFO between the UART receiver and the Morse generator: normalises each character,
// drives the generator's start/done handshake and pads letters with the inter-letter gap.
`timescale 1ns/1ps
module morse_char_sequencer #(
    parameter int MORSE_CYCLES = 10,
    parameter int FIFO_DEPTH   = 16,
    parameter int GAP_UNITS    = 2
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [7:0]                    wr_data_i,
    input  logic                          wr_valid_i,
    output logic                          wr_ready_o,
    output logic [7:0]                    ascii_o,
    output logic                          start_o,
    input  logic                          gen_done_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          overflow_o,
    output logic                          busy_o
);

    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam int              CW        = AW + 1;
    localparam logic [CW-1:0]   DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [31:0]     GAP_TOTAL = 32'(GAP_UNITS * MORSE_CYCLES);
    localparam logic [31:0]     GAP_LAST  = (GAP_TOTAL == 32'd0) ? 32'd0 : GAP_TOTAL - 32'd1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_REL  = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]    state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   gap_cnt;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign push         = wr_valid_i && !full;
    // Pop looks only at the registered count, so a byte pushed this cycle waits one cycle.
    assign pop          = (state == S_IDLE) && !empty;
    assign wr_ready_o   = !full;
    assign fifo_count_o = count;
    assign busy_o       = (state != S_IDLE) || !empty;

    function automatic logic [7:0] normalise(input logic [7:0] c);
        if (c >= 8'h61 && c <= 8'h7A) return c - 8'h20;
        if (c == 8'h0D || c == 8'h0A) return 8'h20;
        return c;
    endfunction

    // NOTE: the storage array is deliberately not reset; pointers and count alone define
    // which entries are valid, which keeps the array mappable onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= wr_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (wr_valid_i && full) overflow_o <= 1'b1;
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: every register here uses non-blocking assignment so each next-state term reads
    // the pre-edge value of state, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state   <= S_IDLE;
            ascii_o <= 8'h00;
            start_o <= 1'b0;
            gap_cnt <= '0;
        end else begin
            // Registered request; gating with done keeps start low while the generator reports done.
            start_o <= (state == S_REQ) && !gen_done_i;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        ascii_o <= normalise(mem[rd_ptr]);
                        state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (gen_done_i) state <= S_REL;
                end
                S_REL: begin
                    if (!gen_done_i) begin
                        if (ascii_o != 8'h20 && GAP_TOTAL != 32'd0) begin
                            gap_cnt <= '0;
                            state   <= S_GAP;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 32'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
